adder_32b: RTL and testbench

- 32-bit integer adder/subtractor for the RISC-V datapath, e.g. PC+4 and address or immediate sums.
- Computes A+B, or A−B when subtraction is selected.
- Result and ALU-style status flags are registered, so the datapath sees a fixed one-cycle latency.
- Pure datapath block: no backpressure, no internal state beyond the output register stage.

---
 rtl/adder_32b.sv | 54 +++++
 tb/tb_adder_32b.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_32b.sv
// WIDTH-bit add/subtract with registered result and ALU flags; latency 1 cycle.
// No backpressure: one operation accepted per cycle, never stalls; outputs hold when in_valid=0.
module adder_32b #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Adder_Result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             out_valid
);

  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             ovf;

  // Subtraction is A + ~B + 1, so the overflow rule for both operations
  // reduces to: operands (as actually added) share a sign the result lacks.
  always_comb begin
    b_op = sub ? ~B : B;
    sum  = {1'b0, A} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub};
    res  = sum[WIDTH-1:0];
    ovf  = (A[WIDTH-1] == b_op[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Adder_Result <= '0;
      carry_out    <= 1'b0;
      overflow     <= 1'b0;
      zero         <= 1'b1;
      negative     <= 1'b0;
      out_valid    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Adder_Result <= res;
        carry_out    <= sum[WIDTH];
        overflow     <= ovf;
        zero         <= (res == '0);
        negative     <= res[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_adder_32b.sv
// Scoreboard bench for adder_32b: expected results queued at drive time, popped on out_valid.
module tb_adder_32b;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        ov;
    logic        z;
    logic        n;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        sub = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] Adder_Result;
  logic        carry_out, overflow, zero, negative, out_valid;

  int   n_total = 0;
  int   n_pass  = 0;
  bit   mon_en  = 1'b0;
  logic exp_vld = 1'b0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  adder_32b #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sub(sub), .A(A), .B(B),
    .Adder_Result(Adder_Result), .carry_out(carry_out), .overflow(overflow),
    .zero(zero), .negative(negative), .out_valid(out_valid)
  );

  // Reference model using 64-bit signed arithmetic for overflow.
  function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic s);
    exp_t        e;
    longint      sa, sb, sr;
    logic [32:0] w;
    sa = $signed(a);
    sb = $signed(b);
    if (!s) begin
      w  = {1'b0, a} + {1'b0, b};
      sr = sa + sb;
    end else begin
      w  = {1'b0, a} - {1'b0, b};
      sr = sa - sb;
    end
    e.res = w[31:0];
    e.c   = s ? (a >= b) : w[32];
    e.ov  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.z   = (w[31:0] == 32'd0);
    e.n   = w[31];
    return e;
  endfunction

  // Valid expected one cycle after an accepted op; reset discards.
  always @(posedge clk) exp_vld <= in_valid & ~rst;

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      n_total++;
      if (out_valid !== exp_vld)
        $display("FAIL out_valid_timing: got %b expected %b at %0t", out_valid, exp_vld, $time);
      else n_pass++;
      if (out_valid === 1'b1) begin
        n_total++;
        if (sb_q.size() == 0) begin
          $display("FAIL sb_unexpected_output: got result %h with empty scoreboard at %0t", Adder_Result, $time);
        end else begin
          n_pass++;
          e = sb_q.pop_front();
          n_total++;
          if (Adder_Result !== e.res) $display("FAIL result: got %h expected %h at %0t", Adder_Result, e.res, $time);
          else n_pass++;
          n_total++;
          if (carry_out !== e.c) $display("FAIL carry_out: got %b expected %b (res %h) at %0t", carry_out, e.c, e.res, $time);
          else n_pass++;
          n_total++;
          if (overflow !== e.ov) $display("FAIL overflow: got %b expected %b (res %h) at %0t", overflow, e.ov, e.res, $time);
          else n_pass++;
          n_total++;
          if (zero !== e.z) $display("FAIL zero: got %b expected %b (res %h) at %0t", zero, e.z, e.res, $time);
          else n_pass++;
          n_total++;
          if (negative !== e.n) $display("FAIL negative: got %b expected %b (res %h) at %0t", negative, e.n, e.res, $time);
          else n_pass++;
        end
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s, input logic v);
    @(posedge clk);
    #2;
    A = a; B = b; sub = s; in_valid = v;
    if (v && !rst) sb_q.push_back(model(a, b, s));
  endtask

  task automatic drain(input string name);
    drive('0, '0, 1'b0, 1'b0);
    drive('0, '0, 1'b0, 1'b0);
    @(negedge clk);
    n_total++;
    if (sb_q.size() != 0) $display("FAIL %s_drain: got %0d pending results expected 0", name, sb_q.size());
    else n_pass++;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; A = 32'd5; B = 32'd5; sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (Adder_Result !== 32'd0) $display("FAIL reset_result: got %h expected 0", Adder_Result); else n_pass++;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_total++;
    if (zero !== 1'b1) $display("FAIL reset_zero: got %b expected 1", zero); else n_pass++;
    n_total++;
    if ({carry_out, overflow, negative} !== 3'b000)
      $display("FAIL reset_flags: got c/ov/n %b expected 000", {carry_out, overflow, negative});
    else n_pass++;
    @(posedge clk);
    #2;
    rst = 1'b0; in_valid = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_add_sweep;
    logic [31:0] av[6];
    av = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd7};
    foreach (av[i]) drive(av[i], 32'd4, 1'b0, 1'b1);
    drain("add_sweep");
  endtask

  task automatic test_wrap;
    drive(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
    drain("wrap");
    n_total++;
    if ({Adder_Result, carry_out, zero, overflow} !== {32'd0, 1'b1, 1'b1, 1'b0})
      $display("FAIL wrap_const: got res %h c %b z %b ov %b expected 0 1 1 0", Adder_Result, carry_out, zero, overflow);
    else n_pass++;
  endtask

  task automatic test_overflow;
    drive(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1);
    drive(32'h8000_0000, 32'd1, 1'b1, 1'b1);
    drain("overflow");
  endtask

  task automatic test_sub_borrow;
    drive(32'd3, 32'd5, 1'b1, 1'b1);
    drive(32'd5, 32'd5, 1'b1, 1'b1);
    drive(32'd0, 32'd0, 1'b1, 1'b1);
    drain("sub_borrow");
  endtask

  task automatic test_valid_gating;
    drive(32'd2, 32'd4, 1'b0, 1'b1);
    drive(32'd100, 32'd4, 1'b0, 1'b0);
    @(negedge clk);
    n_total++;
    if (out_valid !== 1'b1 || Adder_Result !== 32'd6)
      $display("FAIL gating_first: got vld %b res %h expected 1 00000006", out_valid, Adder_Result);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (out_valid !== 1'b0 || Adder_Result !== 32'd6)
      $display("FAIL gating_hold: got vld %b res %h expected 0 00000006", out_valid, Adder_Result);
    else n_pass++;
    drain("valid_gating");
  endtask

  task automatic test_back_to_back;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: a = 32'h8000_0000;
        1: a = 32'h7FFF_FFFF;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 4) == 0) ? a : $urandom;
      drive(a, b, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end
    drain("back_to_back");
  endtask

  task automatic test_reset_mid_stream;
    drive(32'd10, 32'd20, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1; A = 32'd1; B = 32'd1; in_valid = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0; in_valid = 1'b0;
    drive(32'd7, 32'd8, 1'b0, 1'b1);
    drain("reset_mid");
    n_total++;
    if (Adder_Result !== 32'd15) $display("FAIL reset_mid_result: got %h expected 0000000f", Adder_Result);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_sweep();
    test_wrap();
    test_overflow();
    test_sub_borrow();
    test_valid_gating();
    test_back_to_back();
    test_reset_mid_stream();
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
